// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants and
// receiver status bit positions used by both TX and RX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } tx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        START_BIT      = 1'b0;
  localparam logic        STOP_BIT       = 1'b1;

  // Receiver status word bit positions (parity, framing, break errors)
  localparam int unsigned RX_STAT_PE = 0;
  localparam int unsigned RX_STAT_FE = 1;
  localparam int unsigned RX_STAT_BE = 2;

  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART serializer.
// Writes while full and reads while empty are ignored; full/empty are
// combinational from the occupancy count.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_wrapper.sv
// Buffered UART transmitter: host bytes go into a FIFO, the serializer
// drains it as start / 8 data LSB-first / parity / stop frames followed by
// an idle gap. Define UART_TX_PARITY_EN to include the parity bit
// (11-bit frame); without it the frame is 10 bits and PARITY_ODD is unused.
module uart_tx_wrapper
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_ODD   = 1,
  parameter int unsigned IDLE_BITS    = 1
) (
  input  logic       UART_clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned GAP_W  = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

  tx_state_e                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`else
  logic                      unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  logic                      pop;
  logic                      bit_end;
  logic                      enter_idle;
  logic [UART_DATA_BITS-1:0] fifo_rd;
  logic                      fifo_full, fifo_empty;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (UART_clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign tx       = tx_q;

  // Serializer next-state; the IDLE pop is also evaluated on the last
  // bit-time of the frame tail so back-to-back frames have no extra idle cycle
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    overflow_d = overflow_q | (wr_en & fifo_full);
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    pop        = 1'b0;
    enter_idle = 1'b0;
    bit_end    = (baud_q == BAUD_LAST);
    baud_d     = (state_q == ST_IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      ST_IDLE: enter_idle = 1'b1;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = STOP_BIT;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = STOP_BIT;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (IDLE_BITS > 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
            tx_d    = STOP_BIT;
          end else begin
            enter_idle = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) enter_idle = 1'b1;
          else                   gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_idle) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = fifo_rd;
`ifdef UART_TX_PARITY_EN
        parity_d = calc_parity(fifo_rd, PARITY_ODD != 0);
`endif
        tx_d    = START_BIT;
        busy_d  = 1'b1;
        state_d = ST_START;
      end else begin
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  // Serializer state and registered outputs
  always_ff @(posedge UART_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      gap_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
